// File: rtl/led_pkg.sv
// Shared constants for the keyboard LED display path.
package led_pkg;

  localparam logic [1:0] MODE_STEADY = 2'd0;
  localparam logic [1:0] MODE_BLINK  = 2'd1;
  localparam logic [1:0] MODE_PWM    = 2'd2;
  localparam logic [1:0] MODE_HILITE = 2'd3;

  localparam int unsigned DEF_WIDTH     = 8;
  localparam int unsigned DEF_PWM_BITS  = 4;
  localparam int unsigned DEF_BLINK_DIV = 12500000;
  localparam int unsigned DEF_STRETCH   = 4;

endpackage

// File: rtl/sync_edge.sv
// Three-flop synchroniser for an asynchronous level; o_rise_c pulses for one
// cycle when the synchronised level goes from 0 to 1.
module sync_edge (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_rise_c
);

  logic s1;
  logic s2;
  logic s3;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= i_d;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign o_rise_c = s2 & ~s3;

endmodule

// File: rtl/led_latch_ctrl.sv
// LED latch/driver: captures a value on each ready strobe and drives the LED
// bank steady, blinking, PWM-dimmed or with changed bits highlighted.
module led_latch_ctrl
  import led_pkg::*;
#(
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter int unsigned PWM_BITS  = DEF_PWM_BITS,
  parameter int unsigned BLINK_DIV = DEF_BLINK_DIV,
  parameter int unsigned STRETCH   = DEF_STRETCH
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_ready,
  input  logic [WIDTH-1:0]    i_count,
  input  logic [1:0]          i_mode,
  input  logic [PWM_BITS-1:0] i_bright,
  output logic [WIDTH-1:0]    o_leds,
  output logic                o_update
);

  localparam int unsigned DIV_W = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam int unsigned STR_W = $clog2(STRETCH + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BLINK_DIV - 1);
  localparam logic [STR_W-1:0] STR_LOAD = STR_W'(STRETCH);

  logic                capture_c;
  logic [WIDTH-1:0]    latch;
  logic [WIDTH-1:0]    changed;
  logic [DIV_W-1:0]    presc;
  logic                phase;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [STR_W-1:0]    stretch;
  logic                wrap_c;
  logic                pwm_on_c;
  logic [WIDTH-1:0]    leds_nxt_c;

  sync_edge u_sync (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_d      (i_ready),
    .o_rise_c (capture_c)
  );

  // Output selection from the current registered state.
  always_comb begin
    wrap_c     = (presc == DIV_LAST);
    pwm_on_c   = (pwm_cnt < i_bright);
    leds_nxt_c = latch;
    case (i_mode)
      MODE_STEADY: leds_nxt_c = latch;
      MODE_BLINK:  leds_nxt_c = phase ? latch : '0;
      MODE_PWM:    leds_nxt_c = pwm_on_c ? latch : '0;
      MODE_HILITE: leds_nxt_c = (stretch != '0) ? (latch ^ (changed & {WIDTH{phase}})) : latch;
      default:     leds_nxt_c = latch;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      latch    <= '0;
      changed  <= '0;
      presc    <= '0;
      phase    <= 1'b0;
      pwm_cnt  <= '0;
      stretch  <= '0;
      o_leds   <= '0;
      o_update <= 1'b0;
    end else begin
      presc   <= wrap_c ? '0 : presc + DIV_W'(1);
      pwm_cnt <= pwm_cnt + PWM_BITS'(1);
      if (wrap_c) begin
        phase <= ~phase;
      end
      // A capture restarts the highlight even if a decrement is due.
      if (capture_c) begin
        latch   <= i_count;
        changed <= latch ^ i_count;
        stretch <= STR_LOAD;
      end else if (wrap_c && (stretch != '0)) begin
        stretch <= stretch - STR_W'(1);
      end
      o_update <= capture_c;
      o_leds   <= leds_nxt_c;
    end
  end

endmodule

// File: tb/tb_led_latch_ctrl.sv
// Self-checking bench for led_latch_ctrl with a small cycle model feeding a
// scoreboard of expected {o_leds, o_update}.
module tb_led_latch_ctrl;

  localparam int unsigned W    = 8;
  localparam int unsigned PB   = 4;
  localparam int unsigned BDIV = 4;
  localparam int unsigned STR  = 2;

  logic          i_clk;
  logic          i_rst;
  logic          i_ready;
  logic [W-1:0]  i_count;
  logic [1:0]    i_mode;
  logic [PB-1:0] i_bright;
  logic [W-1:0]  o_leds;
  logic          o_update;

  int n_checks = 0;
  int n_errors = 0;
  int upd_cnt  = 0;

  logic [W:0] exp_q[$];

  // Reference model state
  logic [2:0]   m_sync;
  logic [W-1:0] m_latch;
  logic [W-1:0] m_chg;
  int           m_presc;
  logic         m_phase;
  int           m_pwm;
  int           m_str;
  logic         n_rise;
  logic         n_wrap;
  logic [W-1:0] n_leds;

  led_latch_ctrl #(
    .WIDTH     (W),
    .PWM_BITS  (PB),
    .BLINK_DIV (BDIV),
    .STRETCH   (STR)
  ) dut (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_ready  (i_ready),
    .i_count  (i_count),
    .i_mode   (i_mode),
    .i_bright (i_bright),
    .o_leds   (o_leds),
    .o_update (o_update)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: expected outputs after each edge are queued at that edge.
  always @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      m_sync  <= '0;
      m_latch <= '0;
      m_chg   <= '0;
      m_presc <= 0;
      m_phase <= 1'b0;
      m_pwm   <= 0;
      m_str   <= 0;
      exp_q.delete();
    end else begin
      n_rise = m_sync[1] & ~m_sync[2];
      n_wrap = (m_presc == BDIV - 1);
      case (i_mode)
        2'd1:    n_leds = m_phase ? m_latch : '0;
        2'd2:    n_leds = (m_pwm < int'(i_bright)) ? m_latch : '0;
        2'd3:    n_leds = (m_str > 0) ? (m_latch ^ (m_phase ? m_chg : '0)) : m_latch;
        default: n_leds = m_latch;
      endcase
      exp_q.push_back({n_leds, n_rise});
      m_sync  <= {m_sync[1:0], i_ready};
      m_presc <= n_wrap ? 0 : m_presc + 1;
      m_phase <= n_wrap ? ~m_phase : m_phase;
      m_pwm   <= (m_pwm + 1) % (1 << PB);
      if (n_rise) begin
        m_latch <= i_count;
        m_chg   <= m_latch ^ i_count;
        m_str   <= STR;
      end else if (n_wrap && m_str > 0) begin
        m_str <= m_str - 1;
      end
    end
  end

  // Scoreboard compare, away from the active edge.
  always @(negedge i_clk) begin
    logic [W:0] e;
    if (o_update === 1'b1) upd_cnt++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("sb_leds", 32'(o_leds), 32'(e[W:1]));
      check("sb_update", 32'(o_update), 32'(e[0]));
    end
  end

  task automatic send(input logic [W-1:0] v, input int hi);
    i_count = v;
    i_ready = 1'b1;
    repeat (hi) @(negedge i_clk);
    i_ready = 1'b0;
  endtask

  initial begin
    int u0;
    int ones;
    i_rst    = 1'b1;
    i_ready  = 1'b0;
    i_count  = '0;
    i_mode   = 2'd0;
    i_bright = '0;
    @(negedge i_clk);
    check("init_leds", 32'(o_leds), 32'h0);
    check("init_update", 32'(o_update), 32'h0);
    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;
    repeat (4) @(negedge i_clk);

    // Reset mid-capture with ready held high
    i_count = 8'hFF;
    i_ready = 1'b1;
    @(posedge i_clk);
    #2 i_rst = 1'b1;
    #1;
    check("rst_leds", 32'(o_leds), 32'h0);
    check("rst_update", 32'(o_update), 32'h0);
    repeat (2) @(negedge i_clk);
    u0 = upd_cnt;
    i_rst = 1'b0;
    repeat (8) @(negedge i_clk);
    check("rst_one_capture", 32'(upd_cnt - u0), 32'd1);
    check("rst_leds_ff", 32'(o_leds), 32'hFF);
    i_ready = 1'b0;
    repeat (4) @(negedge i_clk);

    // Mode 0 latency and held-high ready
    i_count = 8'hA5;
    i_ready = 1'b1;
    @(posedge i_clk);
    @(posedge i_clk);
    @(negedge i_clk);
    check("lat_upd_k1", 32'(o_update), 32'h0);
    @(posedge i_clk);
    @(negedge i_clk);
    check("lat_upd_k2", 32'(o_update), 32'h1);
    check("lat_leds_k2", 32'(o_leds), 32'hFF);
    @(negedge i_clk);
    check("lat_upd_k3", 32'(o_update), 32'h0);
    check("lat_leds_k3", 32'(o_leds), 32'hA5);
    u0 = upd_cnt;
    repeat (50) @(negedge i_clk);
    check("held_no_recapture", 32'(upd_cnt - u0), 32'd0);
    i_ready = 1'b0;
    repeat (3) @(negedge i_clk);

    // Mode 1 blink
    send(8'h0F, 6);
    repeat (2) @(negedge i_clk);
    i_mode = 2'd1;
    repeat (24) @(negedge i_clk);

    // Mode 2 duty
    i_mode = 2'd0;
    send(8'h01, 6);
    repeat (2) @(negedge i_clk);
    i_mode   = 2'd2;
    i_bright = 4'd5;
    repeat (2) @(negedge i_clk);
    ones = 0;
    repeat (16) begin
      @(negedge i_clk);
      ones += int'(o_leds[0]);
    end
    check("pwm_duty5", 32'(ones), 32'd5);
    i_bright = 4'd0;
    ones = 0;
    repeat (16) begin
      @(negedge i_clk);
      ones += int'(o_leds[0]);
    end
    check("pwm_duty0", 32'(ones), 32'd0);

    // Mode 3 highlight, then recapture of the same value
    i_mode = 2'd0;
    send(8'h00, 6);
    repeat (2) @(negedge i_clk);
    i_mode = 2'd3;
    send(8'h03, 6);
    repeat (16) @(negedge i_clk);
    check("hilite_settled", 32'(o_leds), 32'h03);
    u0 = upd_cnt;
    send(8'h03, 6);
    repeat (12) @(negedge i_clk);
    check("same_value_update", 32'(upd_cnt - u0), 32'd1);
    check("same_value_steady", 32'(o_leds), 32'h03);

    // Overlapping capture during an active highlight, then mode switch
    send(8'h00, 3);
    @(negedge i_clk);
    send(8'h30, 5);
    repeat (3) @(negedge i_clk);
    i_mode = 2'd0;
    @(negedge i_clk);
    check("switch_to_steady", 32'(o_leds), 32'h30);

    // Reset during an active highlight
    i_mode = 2'd3;
    send(8'h0F, 6);
    repeat (2) @(negedge i_clk);
    @(posedge i_clk);
    #2 i_rst = 1'b1;
    #1;
    check("rst_hilite_leds", 32'(o_leds), 32'h0);
    check("rst_hilite_update", 32'(o_update), 32'h0);
    repeat (2) @(negedge i_clk);
    u0 = upd_cnt;
    i_rst = 1'b0;
    repeat (10) @(negedge i_clk);
    check("rst_no_update", 32'(upd_cnt - u0), 32'd0);
    check("rst_leds_clear", 32'(o_leds), 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/led_latch_ctrl.md
Name: led_latch_ctrl

Overview:
- Parametrised LED latch/driver for the keyboard display path.
- Captures a WIDTH-bit value on each rising edge of an asynchronous ready strobe, then drives the LED bank in one of four modes: steady, blink, PWM-dimmed, or change-highlight.
- Sits between the scan-code/count logic and the board LED pins.
- Everything is synchronous to i_clk.

Parameters:
- WIDTH, 8: number of LEDs and width of the captured value.
- PWM_BITS, 4: PWM counter and brightness width.
- BLINK_DIV, 12500000: i_clk cycles per blink half-period; must be ≥2.
- STRETCH, 4: number of blink half-periods a change-highlight lasts; must be ≥1.

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  asynchronous active-high reset.
- i_ready  in  1  capture strobe from another clock domain; level, rising edge significant.
- i_count  in  WIDTH  value to capture; source holds it stable ≥4 i_clk cycles after i_ready rises.
- i_mode  in  2  display mode: 0 steady, 1 blink, 2 PWM, 3 highlight.
- i_bright  in  PWM_BITS  PWM duty for mode 2.
- o_leds  out  WIDTH  registered LED drive, 1 = on.
- o_update  out  1  one-cycle pulse, registered, marking that a capture occurred.

Behaviour:
- Reset (async, i_rst=1) clears all of the following to 0 immediately; all leave reset at the next i_clk edge after i_rst falls:
  - sync flops, latch, changed mask
  - blink prescaler, blink phase
  - PWM counter, stretch counter
  - o_leds, o_update
- Synchroniser:
  - i_ready passes through 2 flops (s1, s2), then a third flop s3; edge = s2 & ~s3.
  - If i_ready is sampled high at edge k, edge is true during the cycle after edge k+1.
  - At edge k+2: latch <= i_count, changed <= latch ^ i_count, o_update <= 1.
  - At edge k+3: o_leds reflects the new latch in mode 0.
  - A held-high i_ready gives exactly one capture.
  - Pulses shorter than one i_clk period may be missed; this is allowed.
- Blink prescaler:
  - Free-running 0..BLINK_DIV-1.
  - At wrap to 0, phase toggles.
  - If the stretch counter is >0 at that wrap, it decrements.
- PWM counter:
  - Free-running 0..2^PWM_BITS-1, wraps naturally.
  - pwm_on = (pwm_cnt < i_bright), so i_bright=0 is always off and the maximum value gives (2^P-1)/2^P duty.
- o_leds next value, by mode:
  - 0: latch.
  - 1: phase ? latch : 0.
  - 2: pwm_on ? latch : 0.
  - 3: (stretch>0) ? latch ^ (changed & {WIDTH{phase}}) : latch.
- Stretch counter:
  - Loaded with STRETCH at every capture.
  - Capture wins over a simultaneous decrement.
  - A new capture during an active highlight reloads the counter and replaces the changed mask.
- i_mode and i_bright are sampled every cycle; a change takes effect on o_leds at the next edge with no glitch beyond that.
- Capture of a value equal to latch:
  - o_update still pulses.
  - changed = 0, so mode 3 shows steady.
- Reset asserted mid-highlight or mid-capture: the pending edge is discarded and no o_update occurs after reset.

Decomposition:
- Package led_pkg holds:
  - mode constants: MODE_STEADY=2'd0, MODE_BLINK=2'd1, MODE_PWM=2'd2, MODE_HILITE=2'd3
  - default parameter values
- One sub-module, sync_edge: a 3-flop synchroniser with rising-edge pulse output, with its own i_clk/i_rst. It is reused by other keyboard blocks.
- Prescaler, PWM, latch and output mux live in led_latch_ctrl.

Test Plan:
- Reset check (BLINK_DIV=4, STRETCH=2 throughout): assert i_rst mid-cycle with i_count=8'hFF and i_ready=1 → o_leds=0 and o_update=0 immediately; after release with i_ready still high, exactly one capture → o_leds=8'hFF in mode 0.
- Mode 0 latency: i_count=8'hA5, raise i_ready at edge k → o_update=1 for the single cycle after edge k+2, o_leds=8'hA5 after edge k+3; i_ready held high 50 cycles → no second o_update.
- Mode 1: latch 8'h0F → o_leds alternates 8'h0F / 8'h00 every 4 cycles.
- Mode 2 duty: latch 8'h01, i_bright=4'd5 → bit0 on exactly 5 of every 16 cycles; i_bright=0 → always 0.
- Mode 3 highlight: latch 8'h00, then 8'h03 → bits1:0 toggle with phase for 2 half-periods (8 cycles), then steady 8'h03; recapture of 8'h03 → o_update pulses, o_leds steady.
- Mode 3 overlap and mode switch: a second capture (8'h30) during an active highlight → counter reloads and only bits5:4 flash; switching i_mode 3→0 mid-highlight → o_leds=8'h30 at the next edge.
